// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - byte-serial instruction fetch with prefetch FIFO
//
// Purpose:
//   Walks byte-addressed instruction memory one byte per clock, assembles
//   big-endian words, buffers them in a small prefetch FIFO and offers the
//   head word to the controller over a valid/ready handshake. Supports PC
//   redirect (flushes the FIFO) and a sticky halt that only reset clears.
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst            asynchronous active-low reset
//   mem_addr       byte address presented to instruction memory (pc + byte_idx)
//   mem_rdata      byte at mem_addr, combinational
//   instr          FIFO head word (0 when empty)
//   instr_pc       byte address of the head word (0 when empty)
//   instr_valid    FIFO non-empty
//   instr_ready    controller accepts the head this cycle
//   redirect_valid load redirect_pc and flush
//   redirect_pc    new byte PC, low two bits ignored
//   halt_req       stop fetching until reset
//   halted         fetch stopped
module instr_fetch #(
  parameter int N     = 32,
  parameter int M     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [M+1:0] mem_addr,
  input  logic [7:0]   mem_rdata,
  output logic [N-1:0] instr,
  output logic [M+1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect_valid,
  input  logic [M+1:0] redirect_pc,
  input  logic         halt_req,
  output logic         halted
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_STALL  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [M+1:0] PC_STEP  = (M+2)'(4);
  localparam logic [PW:0]  CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]  CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [1:0]     state_q, state_d;
  logic [M+1:0]   pc_q, pc_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  // Bytes 0..2 of the word in progress; byte 3 is taken straight from
  // mem_rdata in the push cycle.
  logic [N-9:0]   asm_q, asm_d;

  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]    count_q, count_d;

  logic [N-1:0]   fifo_data_mem [DEPTH];
  logic [M+1:0]   fifo_pc_mem   [DEPTH];

  logic           pop;
  logic           push;
  logic           push_ok;
  logic           active;
  logic           do_halt;
  logic           do_redirect;
  logic [N-1:0]   push_word;
  logic           unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  // A pop in the same cycle frees a slot, so push is legal even when full.
  assign push_ok     = (count_q != CNT_FULL) || pop;
  assign active      = (state_q != ST_HALTED);
  assign do_halt     = active && halt_req;
  assign do_redirect = active && !halt_req && redirect_valid;
  assign push_word   = {asm_q, mem_rdata};

  assign mem_addr = pc_q + {{M{1'b0}}, byte_idx_q};
  assign halted   = (state_q == ST_HALTED);
  assign instr    = instr_valid ? fifo_data_mem[rd_ptr_q] : '0;
  assign instr_pc = instr_valid ? fifo_pc_mem[rd_ptr_q]   : '0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    push       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (do_halt) begin
          state_d = ST_HALTED;
        end else if (do_redirect) begin
          pc_d       = {redirect_pc[M+1:2], 2'b00};
          byte_idx_d = 2'd0;
        end else begin
          case (byte_idx_q)
            2'd0:    asm_d[N-9  -: 8] = mem_rdata;
            2'd1:    asm_d[N-17 -: 8] = mem_rdata;
            2'd2:    asm_d[N-25 -: 8] = mem_rdata;
            default: ;
          endcase
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else if (push_ok) begin
            push       = 1'b1;
            pc_d       = pc_q + PC_STEP;
            byte_idx_d = 2'd0;
          end else begin
            state_d = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (do_halt) begin
          state_d = ST_HALTED;
        end else if (do_redirect) begin
          pc_d       = {redirect_pc[M+1:2], 2'b00};
          byte_idx_d = 2'd0;
          state_d    = ST_FETCH;
        end else if (pop) begin
          push       = 1'b1;
          pc_d       = pc_q + PC_STEP;
          byte_idx_d = 2'd0;
          state_d    = ST_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_redirect) begin
      // Flush wins over any same-cycle pop.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= '0;
      byte_idx_q <= 2'd0;
      asm_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by instr_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_q] <= push_word;
      fifo_pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam int M  = 10;
  localparam int AW = M + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt_req;
  logic          halted;

  logic [7:0] mem [0:4095];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  instr_fetch #(.N(32), .M(M), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted)
  );

  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    int b;
    b = int'({a[AW-1:2], 2'b00});
    return {mem[b], mem[b+1], mem[b+2], mem[b+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
  endtask

  task automatic apply_reset(input logic rdy);
    rst = 1'b0;
    instr_ready = rdy;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    fill_mem();
    rst = 1'b0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 000", mem_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
    checks++; if (instr_pc !== 12'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 000", instr_pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
  endtask

  task automatic test_first_words();
    fill_mem();
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    apply_reset(1'b1);
    repeat (3) tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid: got %b expected 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h01020304 || instr_pc !== 12'h0) begin
      errors++; $display("FAIL first_word: got v=%b %h@%h expected v=1 01020304@000", instr_valid, instr, instr_pc); end
    repeat (4) tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h05060708 || instr_pc !== 12'h4) begin
      errors++; $display("FAIL second_word: got v=%b %h@%h expected v=1 05060708@004", instr_valid, instr, instr_pc); end
  endtask

  task automatic test_stall_full();
    logic [AW-1:0] pcs [$];
    fill_mem();
    apply_reset(1'b0);
    repeat (30) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 12'h0) begin
      errors++; $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=000", instr_valid, instr_pc); end
    checks++; if (mem_addr !== 12'h013) begin errors++; $display("FAIL stall_mem_addr: got %h expected 013", mem_addr); end
    instr_ready = 1'b1;
    for (int c = 0; c < 40 && pcs.size() < 5; c++) begin
      if (instr_valid) begin
        checks++; if (instr !== word_at(instr_pc)) begin
          errors++; $display("FAIL stall_drain_data: got %h expected %h at pc %h", instr, word_at(instr_pc), instr_pc); end
        pcs.push_back(instr_pc);
      end
      tick();
    end
    checks++; if (pcs.size() != 5) begin errors++; $display("FAIL stall_drain_count: got %0d expected 5", pcs.size()); end
    for (int i = 0; i < pcs.size(); i++) begin
      checks++; if (pcs[i] !== AW'(4 * i)) begin
        errors++; $display("FAIL stall_drain_order: got %h expected %h", pcs[i], AW'(4 * i)); end
    end
  endtask

  task automatic test_redirect();
    fill_mem();
    apply_reset(1'b0);
    repeat (10) tick();
    checks++; if (mem_addr !== 12'h00A) begin errors++; $display("FAIL redir_setup_addr: got %h expected 00a", mem_addr); end
    redirect_valid = 1'b1; redirect_pc = 12'h041;
    tick();
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got valid=%b expected 0", instr_valid); end
    checks++; if (mem_addr !== 12'h040) begin errors++; $display("FAIL redir_mem_addr: got %h expected 040", mem_addr); end
    instr_ready = 1'b1;
    for (int c = 0; c < 10 && !instr_valid; c++) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 12'h040 || instr !== word_at(12'h040)) begin
      errors++; $display("FAIL redir_word: got v=%b %h@%h expected v=1 %h@040", instr_valid, instr, instr_pc, word_at(12'h040)); end
  endtask

  task automatic test_wrap();
    fill_mem();
    apply_reset(1'b1);
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 12'hFFC;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 12'hFFC || instr !== word_at(12'hFFC)) begin
      errors++; $display("FAIL wrap_last: got v=%b %h@%h expected v=1 %h@ffc", instr_valid, instr, instr_pc, word_at(12'hFFC)); end
    checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL wrap_mem_addr: got %h expected 000", mem_addr); end
    repeat (4) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 12'h000 || instr !== word_at(12'h000)) begin
      errors++; $display("FAIL wrap_first: got v=%b %h@%h expected v=1 %h@000", instr_valid, instr, instr_pc, word_at(12'h000)); end
  endtask

  task automatic test_halt();
    int n;
    fill_mem();
    apply_reset(1'b0);
    repeat (14) tick();
    checks++; if (mem_addr !== 12'h00E) begin errors++; $display("FAIL halt_setup_addr: got %h expected 00e", mem_addr); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (halted !== 1'b1 || mem_addr !== 12'h00E) begin
      errors++; $display("FAIL halt_enter: got halted=%b addr=%h expected 1 00e", halted, mem_addr); end
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 12'h080;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_addr !== 12'h00E || instr_valid !== 1'b1 || instr_pc !== 12'h0 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_ignore_redir: got addr=%h v=%b pc=%h h=%b expected 00e 1 000 1", mem_addr, instr_valid, instr_pc, halted); end
    instr_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (instr_valid) begin
        checks++; if (instr_pc !== AW'(4 * n) || instr !== word_at(AW'(4 * n))) begin
          errors++; $display("FAIL halt_drain: got %h@%h expected %h@%h", instr, instr_pc, word_at(AW'(4 * n)), AW'(4 * n)); end
        n++;
      end
      tick();
    end
    checks++; if (n != 3) begin errors++; $display("FAIL halt_drain_count: got %0d expected 3", n); end
    apply_reset(1'b0);
    repeat (2) tick();
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h080;
    tick();
    halt_req = 1'b0; redirect_valid = 1'b0;
    checks++; if (halted !== 1'b1 || mem_addr !== 12'h002) begin
      errors++; $display("FAIL halt_priority: got halted=%b addr=%h expected 1 002", halted, mem_addr); end
  endtask

  task automatic test_async_reset();
    fill_mem();
    apply_reset(1'b0);
    repeat (18) tick();
    checks++; if (instr_valid !== 1'b1 || mem_addr !== 12'h012) begin
      errors++; $display("FAIL areset_setup: got v=%b addr=%h expected 1 012", instr_valid, mem_addr); end
    #2 rst = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || mem_addr !== 12'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL areset_immediate: got v=%b i=%h a=%h h=%b expected 0 0 0 0", instr_valid, instr, mem_addr, halted); end
    @(negedge clk);
    rst = 1'b1;
    instr_ready = 1'b1;
    repeat (4) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 12'h0 || instr !== word_at(12'h0)) begin
      errors++; $display("FAIL areset_restart: got v=%b %h@%h expected 1 %h@000", instr_valid, instr, instr_pc, word_at(12'h0)); end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] rpc;
    logic          redir;
    logic          prev_hold;
    logic [31:0]   prev_instr;
    logic [AW-1:0] prev_pc;
    int            pops;
    fill_mem();
    apply_reset(1'b0);
    exp_pc = '0; prev_hold = 1'b0; prev_instr = '0; prev_pc = '0; pops = 0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_hold) begin
        checks++; if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc) begin
          errors++; $display("FAIL rand_hold: got v=%b %h@%h expected 1 %h@%h", instr_valid, instr, instr_pc, prev_instr, prev_pc); end
      end
      if (((i / 300) % 2) == 1) instr_ready = ($urandom_range(0, 7) == 0);
      else instr_ready = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 39) == 0);
      rpc = AW'($urandom);
      redirect_valid = redir;
      redirect_pc = rpc;
      if (redir) begin
        exp_pc = {rpc[AW-1:2], 2'b00};
      end else if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== exp_pc || instr !== word_at(exp_pc)) begin
          errors++; $display("FAIL rand_pop: got %h@%h expected %h@%h", instr, instr_pc, word_at(exp_pc), exp_pc); end
        exp_pc = exp_pc + AW'(4);
        pops++;
      end
      prev_hold = instr_valid && !instr_ready && !redir;
      prev_instr = instr;
      prev_pc = instr_pc;
      tick();
    end
    redirect_valid = 1'b0;
    checks++; if (pops < 200) begin errors++; $display("FAIL rand_progress: got %0d pops expected at least 200", pops); end
  endtask

  initial begin
    test_reset();
    test_first_words();
    test_stall_full();
    test_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
